// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_pkg
// Description : Shared state encoding, BCD limit and digit clamp helper for
//               the BCD down timer.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } bcd_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_dn.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_dn
// Description : One BCD decade of a down counter with load and borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_dn
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);

    // Borrow ripples only through digits that are already zero.
    assign bout = bin && (q == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= ld_val;
        end else if (dec && bin) begin
            q <= (q == 4'd0) ? BCD_MAX : (q - 4'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_timer
// Description : Cascaded BCD down timer with load/start/pause handshakes.
//               Define BCD_TIMER_AUTO_RELOAD_EN to reload on terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic                start,
    input  logic [4*DIGITS-1:0] data,
    output logic [4*DIGITS-1:0] dout,
    output logic                bout,
    output logic                done,
    output logic                busy
);

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_RUN   = ST_RUN;
    localparam logic [1:0] c_ST_PAUSE = ST_PAUSE;
    localparam logic [1:0] c_ST_DONE  = ST_DONE;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [4*DIGITS-1:0] r_reload;
    logic [4*DIGITS-1:0] w_data_clamp;
    logic [4*DIGITS-1:0] w_ld_val;
    logic [DIGITS:0]     w_borrow;
    logic                w_zero;
    logic                w_data_nz;
    logic                w_terminal;
    logic                w_reload_hit;
    logic                w_dec;
    logic                w_ld;
    logic                r_bout;
    logic                r_done;
    logic                r_busy;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
            assign w_data_clamp[4*gi +: 4] = bcd_clamp(data[4*gi +: 4]);
        end
    endgenerate

    // The borrow out of the top decade is set only when every digit is zero.
    assign w_zero     = w_borrow[DIGITS];
    assign w_data_nz  = |w_data_clamp;
    assign w_terminal = !load && (r_state == c_ST_RUN) && en && w_zero;
    assign w_dec      = !load && (r_state == c_ST_RUN) && en && !w_zero;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    assign w_reload_hit = w_terminal;
`else
    assign w_reload_hit = 1'b0;
`endif

    assign w_ld     = load || w_reload_hit;
    assign w_ld_val = load ? w_data_clamp : r_reload;

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = (start && w_data_nz) ? c_ST_RUN : c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (start && !w_zero) w_state_nxt = c_ST_RUN;
                c_ST_RUN: begin
                    if (!en) begin
                        w_state_nxt = c_ST_PAUSE;
                    end else if (w_zero) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        w_state_nxt = (r_reload == '0) ? c_ST_IDLE : c_ST_RUN;
`else
                        w_state_nxt = c_ST_DONE;
`endif
                    end
                end
                c_ST_PAUSE: if (en) w_state_nxt = c_ST_RUN;
                c_ST_DONE:  if (start && !w_zero) w_state_nxt = c_ST_RUN;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_reload <= '0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (load) begin
                r_reload <= w_data_clamp;
            end
            r_bout <= w_terminal;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            r_done <= w_terminal;
`else
            r_done <= (w_state_nxt == c_ST_DONE);
`endif
            r_busy <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_PAUSE);
        end
    end

    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_dn u_digit (
                .clk    (clk),
                .rst    (rst),
                .ld     (w_ld),
                .ld_val (w_ld_val[4*gi +: 4]),
                .dec    (w_dec),
                .bin    (w_borrow[gi]),
                .q      (dout[4*gi +: 4]),
                .bout   (w_borrow[gi+1])
            );
        end
    endgenerate

    assign bout = r_bout;
    assign done = r_done;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD decades; legal range 1..4.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; 0 freezes the count.
REQ-005 load  input  1  synchronous load of data into the count and reload registers.
REQ-006 start  input  1  single-cycle request to begin counting down.
REQ-007 data  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0].
REQ-008 dout  output  4*DIGITS  current BCD count.
REQ-009 bout  output  1  borrow-out; one-cycle pulse on the cycle the count wraps past zero.
REQ-010 done  output  1  count has reached zero (level or pulse, per REQ-030/031).
REQ-011 busy  output  1  high while in RUN or PAUSE.

Function
REQ-012 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-013 IDLE -> RUN when start=1 and dout!=0; start with dout==0 is ignored.
REQ-014 RUN -> PAUSE when en=0; PAUSE -> RUN when en=1; the count holds in PAUSE.
REQ-015 In RUN with en=1, dout decrements by exactly 1 (BCD) per clk.
REQ-016 BCD decrement rules: digit 0 -> 9 with borrow to the next digit; other digits -> digit-1 with no borrow.
REQ-017 Count 0..01 -> 0..00: the next cycle enters DONE (non-reload) or reloads (REQ-031); bout pulses on the 00 -> reload/DONE transition cycle.
REQ-018 load=1 in any state: dout <= data and reload register <= data on the next edge; the state goes to IDLE unless start=1 in the same cycle, in which case the state goes to RUN if data!=0.
REQ-019 load has priority over en and over decrement in the same cycle.
REQ-020 Any data digit >9 is clamped to 9 on load, for both dout and the reload register.
REQ-021 start in RUN or PAUSE is ignored.
REQ-022 DONE -> RUN on start=1 when dout!=0 (after a load); DONE -> IDLE on load without start.
REQ-023 busy is a registered decode of the state; bout and done are registered; latency from edge to output is 0 cycles.
REQ-024 DIGITS=1: behaves as a single decade 9..0 counter with identical handshakes.

Reset
REQ-025 rst=1 forces, asynchronously: state=IDLE, dout=0, reload register=0, bout=0, done=0, busy=0.
REQ-026 Reset asserted mid-count aborts the count; no bout is generated and reset values hold until the first edge after rst=0.
REQ-027 The first edge after deassertion obeys normal rules, including load or start on that edge.

Configuration
REQ-028 Macro BCD_TIMER_AUTO_RELOAD_EN selects the terminal behaviour.
REQ-029 Both configurations share an identical port list.
REQ-030 Macro undefined: on terminal count, state=DONE, dout holds 0, done is held at 1 until load or start leaves DONE.
REQ-031 Macro defined: on terminal count, dout <= reload register, the state stays RUN, and done pulses high for one cycle together with bout; the DONE state is unreachable; a reload value of 0 forces IDLE instead.

Structure
REQ-032 Package bcd_timer_pkg holds the state enum, the constant BCD_MAX=4'd9, and the function bcd_clamp(4-bit).
REQ-033 Sub-module bcd_digit_dn: one decade with inputs clk, rst, ld, ld_val, dec, bin and outputs q[3:0], bout, instantiated DIGITS times in a borrow chain.
REQ-034 Top-level bcd_down_timer contains the FSM, the reload register and the output registers only.

Verification
REQ-035 Load data=8'h12, start, en=1 -> dout sequence 12,11,10,09,...,00; bout pulse 1 cycle; done=1 (non-reload).
REQ-036 Load data=8'h03, start, then en=0 for 4 cycles after dout=02 -> busy=1, dout holds 02, resumes to 01,00 when en=1.
REQ-037 Load data=8'hAF -> dout=8'h99; start -> next dout=98.
REQ-038 Assert rst for half a cycle at dout=05 during RUN -> dout=00, state IDLE, no bout; start ignored until load.
REQ-039 load=1 and start=1 with data=8'h02 in DONE -> dout=02 next edge, busy=1, then 01,00.
REQ-040 With BCD_TIMER_AUTO_RELOAD_EN, load 8'h02, start -> dout 02,01,00,02,01,00...; bout and done pulse once per period; busy stays 1.
